// File: rtl/expr_pkg.sv
// expr_pkg: shared definitions for the expression-string datapath.
// ASCII codes for the accepted alphabet, the FSM state encoding and
// the character-class encoding used by the recognizer and evaluator.
package expr_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_MUL = 8'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NUM  = 2'd1,
        ST_OP   = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CC_DIG = 2'd0,
        CC_ADD = 2'd1,
        CC_MUL = 2'd2,
        CC_BAD = 2'd3
    } char_class_t;

endpackage

// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, evaluated result out.
//   in, in_valid      : ASCII character and its consume strobe (master -> slave)
//   result            : expression value modulo 2^W        (slave -> master)
//   legal, overflow   : complete-expression and sticky overflow flags
//   state             : FSM state code (0 IDLE, 1 NUM, 2 OP, 3 ERR)
interface expr_eval_if #(
    parameter int W = 16
);
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] result;
    logic         legal;
    logic         overflow;
    logic [1:0]   state;

    modport master (
        output in, in_valid,
        input  result, legal, overflow, state
    );

    modport slave (
        input  in, in_valid,
        output result, legal, overflow, state
    );
endinterface

// File: rtl/expr_char_class.sv
// expr_char_class: combinational ASCII classifier.
//   ch    : ASCII character
//   cls   : CC_DIG / CC_ADD / CC_MUL / CC_BAD
//   digit : numeric value of a digit, 0 for any other class
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_t cls,
    output logic [3:0]  digit
);

    always_comb begin
        cls   = CC_BAD;
        digit = 4'd0;
        if (ch >= CH_0 && ch <= CH_9) begin
            cls   = CC_DIG;
            // '0'..'9' are 0x30..0x39, so the low nibble is the value.
            digit = ch[3:0];
        end else if (ch == CH_ADD) begin
            cls = CC_ADD;
        end else if (ch == CH_MUL) begin
            cls = CC_MUL;
        end
    end

endmodule

// File: rtl/expr_eval.sv
// expr_eval: running evaluator for single-digit '+'/'*' expressions with
// '*' binding tighter than '+'.
//   clk : rising-edge clock
//   clr : asynchronous active-high clear
//   bus : expr_eval_if slave (in/in_valid in; result/legal/overflow/state out)
// The value is held as sum_acc (completed '+' terms) plus prod_acc (the
// product term still being built); mul_pend marks that the next digit
// multiplies into prod_acc instead of starting a new term.
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        clr,
    expr_eval_if.slave  bus
);

    localparam logic [2*W-1:0] MAX_VAL = {{W{1'b0}}, {W{1'b1}}};

    state_t       st;
    logic [W-1:0] sum_acc;
    logic [W-1:0] prod_acc;
    logic         mul_pend;
    logic [W-1:0] result_q;
    logic         legal_q;
    logic         overflow_q;

    char_class_t  cls;
    logic [3:0]   digit;

    expr_char_class u_class (
        .ch    (bus.in),
        .cls   (cls),
        .digit (digit)
    );

    logic           accept;
    logic [2*W-1:0] prod_ext;
    logic [2*W-1:0] dig_ext;
    logic [2*W-1:0] nxt_prod;
    logic [2*W-1:0] nxt_sum;
    logic [2*W-1:0] res_full;
    logic           ovf_now;

    assign accept = ((st == ST_IDLE || st == ST_OP) && cls == CC_DIG) ||
                    (st == ST_NUM && (cls == CC_ADD || cls == CC_MUL));

    assign prod_ext = {{W{1'b0}}, prod_acc};
    assign dig_ext  = {{(2*W-4){1'b0}}, digit};

    always_comb begin
        nxt_prod = prod_ext;
        nxt_sum  = {{W{1'b0}}, sum_acc};
        res_full = '0;
        if (cls == CC_DIG)
            nxt_prod = mul_pend ? prod_ext * dig_ext : dig_ext;
        if (cls == CC_ADD)
            nxt_sum = {{W{1'b0}}, sum_acc} + prod_ext;
        // After '+' the product term is already folded into the sum; the
        // stale prod_acc only survives until the next digit replaces it.
        if (cls == CC_ADD)
            res_full = {{W{1'b0}}, nxt_sum[W-1:0]};
        else
            res_full = {{W{1'b0}}, nxt_sum[W-1:0]} + {{W{1'b0}}, nxt_prod[W-1:0]};
    end

    assign ovf_now = (nxt_prod > MAX_VAL) || (nxt_sum > MAX_VAL) || (res_full > MAX_VAL);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st         <= ST_IDLE;
            sum_acc    <= '0;
            prod_acc   <= '0;
            mul_pend   <= 1'b0;
            result_q   <= '0;
            legal_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.in_valid && st != ST_ERR) begin
            if (accept) begin
                st         <= (cls == CC_DIG) ? ST_NUM : ST_OP;
                legal_q    <= (cls == CC_DIG);
                sum_acc    <= nxt_sum[W-1:0];
                prod_acc   <= nxt_prod[W-1:0];
                mul_pend   <= (cls == CC_MUL);
                result_q   <= res_full[W-1:0];
                if (ovf_now)
                    overflow_q <= 1'b1;
            end else begin
                st      <= ST_ERR;
                legal_q <= 1'b0;
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.legal    = legal_q;
    assign bus.overflow = overflow_q;
    assign bus.state    = st;

endmodule
